connect4_turn_ctrl: RTL and testbench

Turn and move sequencer for the Connect 4 game core. Accepts a column selection from the active player and rejects illegal moves. For each legal move it tracks per-column fill height, issues one board-write for the landing cell, and hands off to the external win checker. It then alternates players or ends the game. It sits between the player-input front end and the board memory / win-check datapath.

---
 rtl/connect4_pkg.sv | 13 +
 rtl/connect4_turn_ctrl_if.sv | 32 +++
 rtl/Counter.sv | 20 ++
 rtl/RangeCheck.sv | 11 +
 rtl/column_heights.sv | 31 +++
 rtl/connect4_turn_ctrl.sv | 144 ++++++++++++++
 tb/tb_connect4_turn_ctrl.sv | 227 ++++++++++++++++++++++
 7 files changed

// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect 4 turn controller.
package connect4_pkg;
  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS + 1);
  localparam int MOVES = ROWS * COLS;
  localparam int MW    = $clog2(MOVES + 1);

  typedef enum logic [1:0] {IDLE, PLACE, CHECK, OVER} state_t;
  typedef enum logic [1:0] {NONE, P1_WIN, P2_WIN, DRAW} result_t;
  typedef logic player_t;
endpackage

// File: rtl/connect4_turn_ctrl_if.sv
// Move request, board write and win-check handshake of the turn controller.
interface connect4_turn_ctrl_if;
  import connect4_pkg::*;

  logic            new_game;
  logic            move_valid;
  logic [CW-1:0]   move_col;
  logic            ready;
  logic            illegal;
  logic            wr_en;
  logic [CW-1:0]   wr_col;
  logic [RW-1:0]   wr_row;
  player_t         wr_player;
  logic            check_start;
  logic            check_done;
  logic            check_win;
  player_t         cur_player;
  logic [COLS-1:0] col_full;
  result_t         result;

  modport master (
    output new_game, move_valid, move_col, check_done, check_win,
    input  ready, illegal, wr_en, wr_col, wr_row, wr_player, check_start,
           cur_player, col_full, result
  );

  modport slave (
    input  new_game, move_valid, move_col, check_done, check_win,
    output ready, illegal, wr_en, wr_col, wr_row, wr_player, check_start,
           cur_player, col_full, result
  );
endinterface

// File: rtl/Counter.sv
// Library up/down counter with load and clear, extended with an async reset.
module Counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
    else if (en)    q <= up ? q + W'(1) : q - W'(1);
  end
endmodule

// File: rtl/RangeCheck.sv
// Library inclusive range comparator.
module RangeCheck #(
  parameter int W = 4
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] low,
  input  logic [W-1:0] high,
  output logic         in_range
);
  assign in_range = (value >= low) && (value <= high);
endmodule

// File: rtl/column_heights.sv
// Per-column fill heights and the combinational full-flag decode.
module column_heights
  import connect4_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     inc_en,
  input  logic [CW-1:0]            inc_col,
  output logic [COLS-1:0][RW-1:0]  heights,
  output logic [COLS-1:0]          col_full
);
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic col_inc;

    assign col_inc = inc_en && (inc_col == CW'(c));

    Counter #(.W(RW)) u_height (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .en    (col_inc),
      .up    (1'b1),
      .load  (1'b0),
      .d     ('0),
      .q     (heights[c])
    );

    assign col_full[c] = (heights[c] == RW'(ROWS));
  end
endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect 4 turn sequencer: validates moves, writes the landing cell,
// runs the external win check, then alternates players or ends the game.
module connect4_turn_ctrl
  import connect4_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  connect4_turn_ctrl_if.slave bus
);
  state_t                    state_q, state_d;
  player_t                   cur_player_q, cur_player_d;
  result_t                   result_q, result_d;
  logic                      wr_en_q, wr_en_d;
  logic                      check_start_q, check_start_d;
  logic                      illegal_q, illegal_d;
  logic [CW-1:0]             col_q;
  logic [RW-1:0]             row_q;
  logic [COLS-1:0][RW-1:0]   heights;
  logic [COLS-1:0]           col_full;
  logic [MW-1:0]             move_count;
  logic [RW-1:0]             sel_height;
  logic                      col_in_range;
  logic                      move_legal;
  logic                      accept;
  logic                      inc_en;

  RangeCheck #(.W(CW)) u_col_range (
    .value    (bus.move_col),
    .low      ('0),
    .high     (CW'(COLS - 1)),
    .in_range (col_in_range)
  );

  // Out-of-range columns never index the height array.
  assign move_legal = col_in_range && !col_full[bus.move_col];
  assign sel_height = col_in_range ? heights[bus.move_col] : '0;
  assign accept     = (state_q == IDLE) && bus.move_valid && move_legal && !bus.new_game;
  assign inc_en     = (state_q == PLACE);

  column_heights u_heights (
    .clock    (clock),
    .reset    (reset),
    .clear    (bus.new_game),
    .inc_en   (inc_en),
    .inc_col  (col_q),
    .heights  (heights),
    .col_full (col_full)
  );

  Counter #(.W(MW)) u_moves (
    .clock (clock),
    .reset (reset),
    .clear (bus.new_game),
    .en    (inc_en),
    .up    (1'b1),
    .load  (1'b0),
    .d     ('0),
    .q     (move_count)
  );

  always_comb begin
    state_d       = state_q;
    cur_player_d  = cur_player_q;
    result_d      = result_q;
    wr_en_d       = 1'b0;
    check_start_d = 1'b0;
    illegal_d     = 1'b0;
    if (bus.new_game) begin
      state_d      = IDLE;
      cur_player_d = 1'b0;
      result_d     = NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.move_valid) begin
            if (move_legal) begin
              state_d = PLACE;
              wr_en_d = 1'b1;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        PLACE: begin
          state_d       = CHECK;
          check_start_d = 1'b1;
        end
        CHECK: begin
          if (bus.check_done) begin
            if (bus.check_win) begin
              result_d = cur_player_q ? P2_WIN : P1_WIN;
              state_d  = OVER;
            end else if (move_count == MW'(MOVES)) begin
              result_d = DRAW;
              state_d  = OVER;
            end else begin
              cur_player_d = ~cur_player_q;
              state_d      = IDLE;
            end
          end
        end
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_player_q  <= 1'b0;
      result_q      <= NONE;
      wr_en_q       <= 1'b0;
      check_start_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_player_q  <= cur_player_d;
      result_q      <= result_d;
      wr_en_q       <= wr_en_d;
      check_start_q <= check_start_d;
      illegal_q     <= illegal_d;
    end
  end

  // Landing cell is captured at acceptance; it is only consumed while wr_en is high.
  always_ff @(posedge clock) begin
    if (accept) begin
      col_q <= bus.move_col;
      row_q <= sel_height;
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.illegal     = illegal_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_col      = col_q;
  assign bus.wr_row      = row_q;
  assign bus.wr_player   = cur_player_q;
  assign bus.check_start = check_start_q;
  assign bus.cur_player  = cur_player_q;
  assign bus.col_full    = col_full;
  assign bus.result      = result_q;
endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Directed bench for connect4_turn_ctrl: vector table plus multi-cycle sequences.
module tb_connect4_turn_ctrl;
  import connect4_pkg::*;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  connect4_turn_ctrl_if bus ();

  connect4_turn_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int ng, mv, col, done, win;
    int e_rdy, e_ill, e_wr, e_col, e_row, e_pl, e_cs, e_cur, e_res;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_new_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
  endtask

  task automatic do_move(input int col, input int win, input int exp_row,
                         input int exp_pl, input int exp_res);
    bus.move_valid = 1'b1;
    bus.move_col   = CW'(col);
    tick();
    bus.move_valid = 1'b0;
    chk("mv_wr_en", int'(bus.wr_en), 1);
    chk("mv_wr_col", int'(bus.wr_col), col);
    chk("mv_wr_row", int'(bus.wr_row), exp_row);
    chk("mv_wr_player", int'(bus.wr_player), exp_pl);
    tick();
    chk("mv_check_start", int'(bus.check_start), 1);
    chk("mv_wr_en_low", int'(bus.wr_en), 0);
    bus.check_done = 1'b1;
    bus.check_win  = (win != 0);
    tick();
    bus.check_done = 1'b0;
    bus.check_win  = 1'b0;
    chk("mv_result", int'(bus.result), exp_res);
    chk("mv_ready", int'(bus.ready), (exp_res == 0) ? 1 : 0);
    chk("mv_cur_player", int'(bus.cur_player), (exp_res == 0) ? 1 - exp_pl : exp_pl);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset          = 1'b1;
    bus.new_game   = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_col   = '0;
    bus.check_done = 1'b0;
    bus.check_win  = 1'b0;

    // fields: ng mv col done win | rdy ill wr col row pl cs cur res
    tbl = '{
      '{0, 1, 3, 0, 0,  0, 0, 1, 3, 0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 1, 0},
      '{0, 1, 7, 0, 0,  1, 1, 0, 0, 0, 0, 0, 1, 0},
      '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1, 0},
      '{0, 1, 3, 0, 0,  0, 0, 1, 3, 1, 1, 0, 1, 0},
      '{0, 1, 5, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0},
      '{0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 1, 6, 0, 0,  0, 0, 1, 6, 0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 1, 0}
    };

    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_illegal", int'(bus.illegal), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_check_start", int'(bus.check_start), 0);
    chk("rst_cur_player", int'(bus.cur_player), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_col_full", int'(bus.col_full), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus.new_game   = (tbl[i].ng != 0);
      bus.move_valid = (tbl[i].mv != 0);
      bus.move_col   = CW'(tbl[i].col);
      bus.check_done = (tbl[i].done != 0);
      bus.check_win  = (tbl[i].win != 0);
      tick();
      chk($sformatf("vec%0d_ready", i), int'(bus.ready), tbl[i].e_rdy);
      chk($sformatf("vec%0d_illegal", i), int'(bus.illegal), tbl[i].e_ill);
      chk($sformatf("vec%0d_wr_en", i), int'(bus.wr_en), tbl[i].e_wr);
      if (tbl[i].e_wr != 0) begin
        chk($sformatf("vec%0d_wr_col", i), int'(bus.wr_col), tbl[i].e_col);
        chk($sformatf("vec%0d_wr_row", i), int'(bus.wr_row), tbl[i].e_row);
        chk($sformatf("vec%0d_wr_player", i), int'(bus.wr_player), tbl[i].e_pl);
      end
      chk($sformatf("vec%0d_check_start", i), int'(bus.check_start), tbl[i].e_cs);
      chk($sformatf("vec%0d_cur_player", i), int'(bus.cur_player), tbl[i].e_cur);
      chk($sformatf("vec%0d_result", i), int'(bus.result), tbl[i].e_res);
    end
    bus.move_valid = 1'b0;
    bus.check_done = 1'b0;

    // Fill column 0, then a seventh request must bounce.
    start_new_game();
    chk("ng_cur_player", int'(bus.cur_player), 0);
    for (int r = 0; r < ROWS; r++) do_move(0, 0, r, r % 2, 0);
    chk("full_col0", int'(bus.col_full), 1);
    bus.move_valid = 1'b1;
    bus.move_col   = '0;
    tick();
    bus.move_valid = 1'b0;
    chk("full_illegal", int'(bus.illegal), 1);
    chk("full_no_wr", int'(bus.wr_en), 0);
    chk("full_ready", int'(bus.ready), 1);
    tick();
    chk("full_illegal_pulse", int'(bus.illegal), 0);
    chk("full_cur_player", int'(bus.cur_player), 0);

    // P2 win.
    start_new_game();
    chk("ng_col_full", int'(bus.col_full), 0);
    do_move(1, 0, 0, 0, 0);
    do_move(1, 1, 1, 1, 2);

    // P1 win, then moves are ignored until new_game.
    start_new_game();
    do_move(2, 1, 0, 0, 1);
    bus.move_valid = 1'b1;
    bus.move_col   = CW'(1);
    tick();
    bus.move_valid = 1'b0;
    chk("over_no_wr", int'(bus.wr_en), 0);
    chk("over_no_illegal", int'(bus.illegal), 0);
    chk("over_ready", int'(bus.ready), 0);
    tick();
    chk("over_result_held", int'(bus.result), 1);
    chk("over_no_wr2", int'(bus.wr_en), 0);
    start_new_game();
    chk("ng2_result", int'(bus.result), 0);
    chk("ng2_ready", int'(bus.ready), 1);
    chk("ng2_cur_player", int'(bus.cur_player), 0);
    do_move(2, 0, 0, 0, 0);

    // Full board with no win ends in a draw.
    start_new_game();
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        do_move(c, 0, r, (c * ROWS + r) % 2, (c * ROWS + r == MOVES - 1) ? 3 : 0);
      end
    end
    chk("draw_col_full", int'(bus.col_full), (1 << COLS) - 1);

    // Async reset while waiting in CHECK.
    start_new_game();
    do_move(4, 0, 0, 0, 0);
    bus.move_valid = 1'b1;
    bus.move_col   = CW'(4);
    tick();
    bus.move_valid = 1'b0;
    tick();
    chk("rstmid_in_check", int'(bus.check_start), 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_ready", int'(bus.ready), 1);
    chk("rstmid_cur_player", int'(bus.cur_player), 0);
    chk("rstmid_check_start", int'(bus.check_start), 0);
    #1 reset = 1'b0;
    bus.check_done = 1'b1;
    tick();
    bus.check_done = 1'b0;
    chk("rstmid_post_cur", int'(bus.cur_player), 0);
    chk("rstmid_post_result", int'(bus.result), 0);
    chk("rstmid_post_wr_en", int'(bus.wr_en), 0);
    chk("rstmid_post_cs", int'(bus.check_start), 0);
    chk("rstmid_post_ready", int'(bus.ready), 1);
    do_move(4, 0, 0, 0, 0);

    // new_game coincident with a winning check_done.
    start_new_game();
    do_move(5, 0, 0, 0, 0);
    bus.move_valid = 1'b1;
    bus.move_col   = CW'(5);
    tick();
    bus.move_valid = 1'b0;
    tick();
    bus.new_game   = 1'b1;
    bus.check_done = 1'b1;
    bus.check_win  = 1'b1;
    tick();
    bus.new_game   = 1'b0;
    bus.check_done = 1'b0;
    bus.check_win  = 1'b0;
    chk("ngdone_ready", int'(bus.ready), 1);
    chk("ngdone_cur_player", int'(bus.cur_player), 0);
    chk("ngdone_result", int'(bus.result), 0);
    chk("ngdone_wr_en", int'(bus.wr_en), 0);
    chk("ngdone_illegal", int'(bus.illegal), 0);
    do_move(5, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
